// File: rtl/shift_add_pkg.sv
// Shared encodings for the shift-add multiplier: register control commands
// and the sequencing FSM state set.
package shift_add_pkg;

  typedef enum logic [1:0] {
    HOLD          = 2'b00,
    SHIFT_RIGHT   = 2'b01,
    SHIFT_LEFT    = 2'b10,
    PARALLEL_LOAD = 2'b11
  } ctrl_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_SHIFT,
    S_DONE
  } state_e;

endpackage

// File: rtl/shift_add_controller.sv
// Sequencer for an N-bit shift-add multiplier: one CHECK/SHIFT pair per
// multiplier bit, then a single-cycle done pulse.
module shift_add_controller
  import shift_add_pkg::*;
#(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       q0,
  output logic [1:0] ctrl_a,
  output logic [1:0] ctrl_q,
  output logic       load_m,
  output logic       clr_acc,
  output logic       add_en,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_LOAD;
        S_LOAD: begin
          cnt   <= '0;
          state <= S_CHECK;
        end
        S_CHECK: state <= S_SHIFT;
        S_SHIFT: begin
          cnt   <= cnt + CW'(1);
          state <= (cnt == LAST) ? S_DONE : S_CHECK;
        end
        S_DONE:  state <= start ? S_LOAD : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state only, except CHECK which follows q0 so the
  // add lands in the same cycle the multiplier bit is examined.
  always_comb begin
    ctrl_a  = HOLD;
    ctrl_q  = HOLD;
    load_m  = 1'b0;
    clr_acc = 1'b0;
    add_en  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_LOAD: begin
        ctrl_a  = PARALLEL_LOAD;
        ctrl_q  = PARALLEL_LOAD;
        load_m  = 1'b1;
        clr_acc = 1'b1;
        busy    = 1'b1;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (q0) begin
          ctrl_a = PARALLEL_LOAD;
          add_en = 1'b1;
        end
      end
      S_SHIFT: begin
        ctrl_a = SHIFT_RIGHT;
        ctrl_q = SHIFT_RIGHT;
        busy   = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_add_controller.sv
// Drives the controller against a behavioural A/Q/M datapath and checks each
// done pulse (timing, product, add/shift/busy counts) from a scoreboard.
module tb_shift_add_controller;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       q0;
  logic [1:0] ctrl_a, ctrl_q;
  logic       load_m, clr_acc, add_en, busy, done;

  shift_add_controller #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .q0(q0),
    .ctrl_a(ctrl_a), .ctrl_q(ctrl_q), .load_m(load_m), .clr_acc(clr_acc),
    .add_en(add_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: accumulator A with carry C, multiplier Q, multiplicand M
  logic [N-1:0] a_r = '0, q_r = '0, m_r = '0;
  logic         c_r = 1'b0;
  logic [N-1:0] mult = '0, mcand = '0;
  assign q0 = q_r[0];

  always @(posedge clk) begin
    if (load_m) m_r <= mcand;
    case (ctrl_a)
      2'b11: begin
        if (clr_acc) begin
          a_r <= '0;
          c_r <= 1'b0;
        end else if (add_en) begin
          {c_r, a_r} <= {1'b0, a_r} + {1'b0, m_r};
        end
      end
      2'b01: begin
        a_r <= {c_r, a_r[N-1:1]};
        c_r <= 1'b0;
      end
      default: ;
    endcase
    case (ctrl_q)
      2'b11: q_r <= mult;
      2'b01: q_r <= {a_r[0], q_r[N-1:1]};
      default: ;
    endcase
  end

  typedef struct {
    int         cyc;
    logic [7:0] prod;
    int         adds;
    int         shifts;
    int         busy_n;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle invariants, then scoreboard pop on every done pulse
  initial begin
    int   n_add, n_sh, n_busy;
    exp_t e;
    n_add = 0; n_sh = 0; n_busy = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        n_add = 0; n_sh = 0; n_busy = 0;
        continue;
      end
      chk("inv_ctrl10", int'(ctrl_a == 2'b10 || ctrl_q == 2'b10), 0);
      chk("inv_add_clr", int'((add_en && clr_acc) || (add_en && ctrl_a != 2'b11)
                              || (clr_acc && ctrl_a != 2'b11)), 0);
      chk("inv_busy_done", int'(busy && done), 0);
      if (busy) n_busy++;
      if (add_en) n_add++;
      if (ctrl_q == 2'b01) n_sh++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("product", int'({a_r, q_r}), int'(e.prod));
          chk("add_count", n_add, e.adds);
          chk("shift_count", n_sh, e.shifts);
          chk("busy_cycles", n_busy, e.busy_n);
        end
        n_add = 0; n_sh = 0; n_busy = 0;
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk);
  endtask

  task automatic run_op(input logic [3:0] mq, input logic [3:0] mm,
                        input logic [7:0] prod, input int adds);
    @(posedge clk); #1;
    mult = mq; mcand = mm; start = 1'b1;
    sb.push_back('{cyc + 10, prod, adds, N, 2 * N + 1});
    @(posedge clk); #1;
    start = 1'b0;
    drain();
  endtask

  typedef struct {
    logic [3:0] mq;
    logic [3:0] mm;
    logic [7:0] prod;
    int         adds;
  } vec_t;

  vec_t vecs[5] = '{
    '{4'b1011, 4'd13, 8'd143, 3},
    '{4'b0000, 4'd9,  8'd0,   0},
    '{4'b1111, 4'd15, 8'd225, 4},
    '{4'b0101, 4'd6,  8'd30,  2},
    '{4'b1000, 4'd7,  8'd56,  1}
  };

  initial begin
    int c;
    #2 rst = 1'b0;
    #1 chk("reset_outputs", int'({ctrl_a, ctrl_q, load_m, clr_acc, add_en, busy, done}), 0);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold_outputs", int'({ctrl_a, ctrl_q, load_m, clr_acc, add_en, busy, done}), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_outputs", int'({ctrl_a, ctrl_q, load_m, clr_acc, add_en, busy, done}), 0);

    foreach (vecs[i]) run_op(vecs[i].mq, vecs[i].mm, vecs[i].prod, vecs[i].adds);

    // start held high: ignored while busy, DONE chains straight into LOAD
    @(posedge clk); #1;
    mult = 4'b1011; mcand = 4'd13; start = 1'b1;
    sb.push_back('{cyc + 10, 8'd143, 3, N, 2 * N + 1});
    sb.push_back('{cyc + 20, 8'd143, 3, N, 2 * N + 1});
    repeat (11) @(posedge clk);
    #1 chk("held_start_load", int'(load_m), 1);
    repeat (9) @(posedge clk);
    #1 start = 1'b0;
    drain();

    // reset during the second SHIFT abandons the op without a done pulse
    @(posedge clk); #1;
    c = cyc;
    mult = 4'b1111; mcand = 4'd5; start = 1'b1;
    sb.push_back('{c + 10, 8'd75, 4, N, 2 * N + 1});
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("second_shift_ctrl", int'(ctrl_q), 1);
    #2 rst = 1'b0;
    #1 chk("midop_reset_outputs",
           int'({ctrl_a, ctrl_q, load_m, clr_acc, add_en, busy, done}), 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    mult = 4'b0110; mcand = 4'd11; start = 1'b1;
    sb.push_back('{cyc + 10, 8'd66, 2, N, 2 * N + 1});
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
